// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit.
//   fetch_state_t   : fetch FSM states (IDLE, REQ, HOLD, FAULT)
//   DEFAULT_TIMEOUT : default number of cycles to wait for imem_ack
//   WORD_ADDR_W     : width of the instruction-memory word address
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam int DEFAULT_TIMEOUT = 16;
    localparam int WORD_ADDR_W     = 30;

endpackage

// File: rtl/fetch_timer.sv
// -----------------------------------------------------------------------------
// fetch_timer
// Counts cycles spent waiting for a memory acknowledge and flags when the
// wait limit is hit.
//   clk     : clock
//   reset   : synchronous active-high reset
//   clear   : return the count to zero
//   enable  : count this cycle (request outstanding, no ack)
//   expired : this cycle's increment reaches TIMEOUT-1
// -----------------------------------------------------------------------------
module fetch_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int         W     = $clog2(TIMEOUT);
    localparam logic [W:0] LIMIT = (W+1)'(TIMEOUT - 1);

    logic [W-1:0] count;
    logic [W:0]   count_inc;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    // Compare the incremented value one bit wider so the limit test never wraps.
    assign count_inc = {1'b0, count} + (W+1)'(1);
    assign expired   = enable && (count_inc == LIMIT);

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Single-outstanding-request instruction fetch unit. Samples pc, issues one
// word request to instruction memory, holds the returned word for the
// downstream stage, and locks into a sticky fault on a misaligned pc, a bus
// error, or an acknowledge timeout.
//   clk, reset       : clock, synchronous active-high reset
//   pc               : byte address from the PC unit
//   flush            : branch/jump taken, discard the fetch in progress
//   pc_stall         : PC unit must hold pc this cycle
//   imem_req/addr    : memory request and word address
//   imem_ack/rdata/err : memory response
//   instruction/instr_pc/instr_valid/instr_ready : downstream handshake
//   fetch_fault      : sticky fault indicator
// -----------------------------------------------------------------------------
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            pc,
    input  logic                   flush,
    output logic                   pc_stall,
    output logic                   imem_req,
    output logic [WORD_ADDR_W-1:0] imem_addr,
    input  logic                   imem_ack,
    input  logic [31:0]            imem_rdata,
    input  logic                   imem_err,
    output logic [31:0]            instruction,
    output logic [31:0]            instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic                   fetch_fault
);

    fetch_state_t state, state_next;
    logic         flush_pending;
    logic         discard;
    logic         timer_clear;
    logic         timer_enable;
    logic         timer_expired;

    // A flush seen at any point during the request kills the returning word.
    assign discard      = flush || flush_pending;
    assign timer_clear  = (state == IDLE);
    assign timer_enable = (state == REQ) && !imem_ack;

    fetch_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An acknowledge always ends the request; flush outranks a bus error.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                state_next = (pc[1:0] != 2'b00) ? FAULT : REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    if (discard) begin
                        state_next = IDLE;
                    end else if (imem_err) begin
                        state_next = FAULT;
                    end else begin
                        state_next = HOLD;
                    end
                end else if (timer_expired) begin
                    state_next = FAULT;
                end
            end
            HOLD: begin
                if (flush || instr_ready) begin
                    state_next = IDLE;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address, pc tag and instruction word only change on their capture events,
    // so they stay stable for the whole request and hold phases.
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_addr     <= '0;
            instr_pc      <= '0;
            instruction   <= '0;
            flush_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    flush_pending <= 1'b0;
                    if (pc[1:0] == 2'b00) begin
                        instr_pc  <= pc;
                        imem_addr <= pc[31:2];
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        flush_pending <= 1'b0;
                        if (!discard && !imem_err) begin
                            instruction <= imem_rdata;
                        end
                    end else if (flush) begin
                        flush_pending <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_req    = (state == REQ);
    assign instr_valid = (state == HOLD);
    assign fetch_fault = (state == FAULT);
    assign pc_stall    = !((state == HOLD) && instr_ready && !flush);

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch: directed scenarios with hand-computed
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the fetch unit.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        flush;
    logic        pc_stall;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_fault;

    int vectors     = 0;
    int miscompares = 0;

    // Model: one outstanding request, one presented word, or dead after a fault.
    bit          m_busy;
    bit          m_have;
    bit          m_dead;
    bit          m_discard;
    int          m_waited;
    logic [29:0] m_addr;
    logic [31:0] m_word;
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    instr_fetch #(
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .flush      (flush),
        .pc_stall   (pc_stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .imem_err   (imem_err),
        .instruction(instruction),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .fetch_fault(fetch_fault)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input logic [31:0] p, input bit f, input bit a,
                                 input bit e, input bit rdy, input logic [31:0] data);
        reset       = r;
        pc          = p;
        flush       = f;
        imem_ack    = a;
        imem_err    = e;
        instr_ready = rdy;
        imem_rdata  = data;
    endtask

    task automatic checkOutput();
        cmp("imem_req",    32'(imem_req),    32'(m_busy));
        cmp("instr_valid", 32'(instr_valid), 32'(m_have));
        cmp("fetch_fault", 32'(fetch_fault), 32'(m_dead));
        cmp("imem_addr",   32'(imem_addr),   32'(m_addr));
        cmp("instruction", instruction,      m_word);
        cmp("instr_pc",    instr_pc,         m_pc);
        cmp("pc_stall",    32'(pc_stall),    32'(!(m_have && instr_ready && !flush)));
    endtask

    task automatic modelStep();
        if (reset) begin
            m_busy = 0; m_have = 0; m_dead = 0; m_discard = 0; m_waited = 0;
            m_addr = '0; m_word = '0; m_pc = '0;
        end else if (m_dead) begin
            m_dead = 1;
        end else if (m_busy) begin
            if (imem_ack) begin
                m_busy = 0;
                if (!(flush || m_discard)) begin
                    if (imem_err) m_dead = 1;
                    else begin
                        m_word = imem_rdata;
                        m_have = 1;
                    end
                end
                m_discard = 0;
            end else begin
                m_waited++;
                if (flush) m_discard = 1;
                if (m_waited == TO - 1) begin
                    m_busy = 0;
                    m_dead = 1;
                end
            end
        end else if (m_have) begin
            if (flush || instr_ready) m_have = 0;
        end else begin
            if (pc[1:0] != 2'b00) m_dead = 1;
            else begin
                m_busy = 1; m_pc = pc; m_addr = pc[31:2]; m_waited = 0; m_discard = 0;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic advance();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    initial begin
        bit          r;
        bit          f;
        logic [31:0] p;

        applyStimulus(1, 32'h0, 0, 0, 0, 0, 32'h0);
        advance();

        // Reset values and minimum-latency fetch
        applyStimulus(0, 32'h00400000, 0, 0, 0, 1, 32'h0);
        settle();
        cmp("rst_req", 32'(imem_req), 32'h0);
        cmp("rst_addr", 32'(imem_addr), 32'h0);
        cmp("rst_stall", 32'(pc_stall), 32'h1);
        cmp("rst_instr", instruction, 32'h0);
        advance();
        applyStimulus(0, 32'h00400000, 0, 1, 0, 1, 32'h2008000A);
        settle();
        cmp("t1_req", 32'(imem_req), 32'h1);
        cmp("t1_addr", 32'(imem_addr), 32'h00100000);
        advance();
        applyStimulus(0, 32'h00400004, 0, 0, 0, 1, 32'h0);
        settle();
        cmp("t1_valid", 32'(instr_valid), 32'h1);
        cmp("t1_instr", instruction, 32'h2008000A);
        cmp("t1_pc", instr_pc, 32'h00400000);
        cmp("t1_stall", 32'(pc_stall), 32'h0);
        advance();
        settle();
        cmp("t1_valid_drop", 32'(instr_valid), 32'h0);
        cmp("t1_stall_back", 32'(pc_stall), 32'h1);
        advance();

        // Five wait cycles, then three HOLD cycles with ready low
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 32'h00400004, 0, 0, 0, 0, 32'h0);
            settle();
            cmp("t2_addr", 32'(imem_addr), 32'h00100001);
            cmp("t2_req", 32'(imem_req), 32'h1);
            advance();
        end
        applyStimulus(0, 32'h00400004, 0, 1, 0, 0, 32'h13000093);
        settle();
        advance();
        applyStimulus(0, 32'h00400004, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            settle();
            cmp("t2_hold_instr", instruction, 32'h13000093);
            cmp("t2_hold_pc", instr_pc, 32'h00400004);
            cmp("t2_hold_stall", 32'(pc_stall), 32'h1);
            advance();
        end
        applyStimulus(0, 32'h00400008, 0, 0, 0, 1, 32'h0);
        settle();
        cmp("t2_ready_stall", 32'(pc_stall), 32'h0);
        advance();

        // Flush in the 2nd REQ cycle, ack in the 4th
        applyStimulus(0, 32'h00400008, 0, 0, 0, 0, 32'h0);
        settle(); advance();
        settle(); advance();
        applyStimulus(0, 32'h00400008, 1, 0, 0, 0, 32'h0);
        settle(); advance();
        applyStimulus(0, 32'h00400008, 0, 0, 0, 0, 32'h0);
        settle(); advance();
        applyStimulus(0, 32'h00400008, 0, 1, 0, 1, 32'hDEADBEEF);
        settle(); advance();
        applyStimulus(0, 32'h00400100, 0, 0, 0, 1, 32'h0);
        settle();
        cmp("t3_idle_req", 32'(imem_req), 32'h0);
        cmp("t3_no_valid", 32'(instr_valid), 32'h0);
        advance();
        applyStimulus(0, 32'h00400100, 0, 1, 0, 1, 32'h00000013);
        settle();
        cmp("t3_new_addr", 32'(imem_addr), 32'h00100040);
        advance();
        settle();
        cmp("t3_new_instr", instruction, 32'h00000013);
        advance();

        // Misaligned pc
        applyStimulus(0, 32'h00400002, 0, 0, 0, 1, 32'h0);
        settle(); advance();
        for (int i = 0; i < 4; i++) begin
            settle();
            cmp("t4_fault", 32'(fetch_fault), 32'h1);
            cmp("t4_req", 32'(imem_req), 32'h0);
            cmp("t4_stall", 32'(pc_stall), 32'h1);
            advance();
        end
        applyStimulus(1, 32'h0, 0, 0, 0, 0, 32'h0);
        settle(); advance();

        // Timeout after TO-1 unacknowledged REQ cycles
        applyStimulus(0, 32'h00400010, 0, 0, 0, 0, 32'h0);
        settle(); advance();
        for (int k = 1; k < TO; k++) begin
            settle();
            cmp("t5_wait_req", 32'(imem_req), 32'h1);
            cmp("t5_wait_fault", 32'(fetch_fault), 32'h0);
            advance();
        end
        settle();
        cmp("t5_timeout", 32'(fetch_fault), 32'h1);
        advance();
        applyStimulus(1, 32'h0, 0, 0, 0, 0, 32'h0);
        settle(); advance();

        // Flush beats imem_err in the acknowledge cycle
        applyStimulus(0, 32'h00400020, 0, 0, 0, 0, 32'h0);
        settle(); advance();
        applyStimulus(0, 32'h00400020, 1, 1, 1, 0, 32'hBAD0BAD0);
        settle(); advance();
        applyStimulus(0, 32'h00400024, 0, 0, 0, 0, 32'h0);
        settle();
        cmp("t6_no_fault", 32'(fetch_fault), 32'h0);
        cmp("t6_idle_req", 32'(imem_req), 32'h0);
        advance();

        // Reset in REQ, stale ack, then reset in HOLD
        applyStimulus(1, 32'h00400024, 0, 0, 0, 0, 32'h0);
        settle(); advance();
        applyStimulus(0, 32'h00400030, 0, 1, 0, 0, 32'h11111111);
        settle();
        cmp("t7_rst_addr", 32'(imem_addr), 32'h0);
        cmp("t7_rst_instr", instruction, 32'h0);
        cmp("t7_rst_pc", instr_pc, 32'h0);
        advance();
        applyStimulus(0, 32'h00400030, 0, 0, 0, 0, 32'h0);
        settle();
        cmp("t7_stale_req", 32'(imem_req), 32'h1);
        cmp("t7_stale_addr", 32'(imem_addr), 32'h0010000C);
        advance();
        applyStimulus(0, 32'h00400030, 0, 1, 0, 0, 32'h00A00093);
        settle(); advance();
        applyStimulus(1, 32'h00400030, 0, 0, 0, 0, 32'h0);
        settle();
        cmp("t7_hold_valid", 32'(instr_valid), 32'h1);
        advance();
        applyStimulus(0, 32'h00400040, 0, 1, 0, 0, 32'h0);
        settle();
        cmp("t7_rst_valid", 32'(instr_valid), 32'h0);
        cmp("t7_rst_instr2", instruction, 32'h0);
        advance();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (m_dead) r = ($urandom_range(0, 7) == 0);
            else        r = ($urandom_range(0, 199) == 0);
            p = $urandom;
            if ($urandom_range(0, 39) != 0) p[1:0] = 2'b00;
            f = ($urandom_range(0, 9) == 0);
            applyStimulus(r, p, f, ($urandom_range(0, 2) == 0), ($urandom_range(0, 11) == 0),
                          ($urandom_range(0, 1) == 0), $urandom);
            settle();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
